// File: rtl/elevator_move_ctrl_if.sv
// Floor-request and car-status bundle between the push-button input block and the controller.
// The master side issues requests; the slave side (the movement controller) reports car state.
interface elevator_move_ctrl_if #(
    parameter int unsigned NUM_FLOORS = 9
);
    logic [4:0]            current;
    logic [4:0]            destination;
    logic                  input_confirm;
    logic [4:0]            car_floor;
    logic [NUM_FLOORS-1:0] car_onehot;
    logic                  moving;
    logic                  dir_up;
    logic                  door_open;
    logic                  busy;
    logic                  req_err;

    modport master (
        output current, destination, input_confirm,
        input  car_floor, car_onehot, moving, dir_up, door_open, busy, req_err
    );

    modport slave (
        input  current, destination, input_confirm,
        output car_floor, car_onehot, moving, dir_up, door_open, busy, req_err
    );
endinterface

// File: rtl/elevator_move_ctrl.sv
// Elevator car movement controller: pickup leg, door, destination leg, door, one floor per tick.
// Define ELEVATOR_REQ_QUEUE_EN to add a one-entry buffer for requests arriving while busy.
module elevator_move_ctrl #(
    parameter int unsigned NUM_FLOORS  = 9,
    parameter int unsigned FLOOR_TICKS = 50,
    parameter int unsigned DOOR_TICKS  = 25
) (
    input  logic                clk,
    input  logic                rst_n,
    elevator_move_ctrl_if.slave bus_if
);
    localparam int unsigned MaxTicks = (FLOOR_TICKS > DOOR_TICKS) ? FLOOR_TICKS : DOOR_TICKS;
    localparam int unsigned TmrW     = $clog2(MaxTicks);
    localparam logic [TmrW-1:0] FloorReload = TmrW'(FLOOR_TICKS - 1);
    localparam logic [TmrW-1:0] DoorReload  = TmrW'(DOOR_TICKS - 1);
    localparam logic [TmrW-1:0] TmrOne      = TmrW'(1);
    localparam logic [4:0]      TopFloor    = 5'(NUM_FLOORS);

    typedef enum logic [2:0] {
        StIdle,
        StGoPick,
        StDoorPick,
        StGoDest,
        StDoorDest
    } state_t;

    state_t                r_state;
    logic [TmrW-1:0]       r_tmr;
    logic [4:0]            r_car_floor;
    logic [NUM_FLOORS-1:0] r_car_onehot;
    logic                  r_dir_up;
    logic                  r_moving;
    logic                  r_door_open;
    logic                  r_busy;
    logic                  r_req_err;
    logic                  r_confirm_d;
    logic [4:0]            r_pick;
    logic [4:0]            r_dest;

    logic                  w_edge;
    logic                  w_in_valid;
    logic [4:0]            w_target;
    logic [4:0]            w_step_floor;
    logic [NUM_FLOORS-1:0] w_step_onehot;
    logic                  w_tmr_done;
    logic                  w_to_idle;
    logic                  w_do_launch;
    logic                  w_req_reject;
    logic [4:0]            w_l_pick;
    logic [4:0]            w_l_dest;

`ifdef ELEVATOR_REQ_QUEUE_EN
    logic                  r_pend_v;
    logic [4:0]            r_pend_pick;
    logic [4:0]            r_pend_dest;
    logic                  w_busy_edge;
`endif

    always_comb begin
        w_edge        = bus_if.input_confirm & ~r_confirm_d;
        w_in_valid    = (bus_if.current != 5'd0) && (bus_if.current <= TopFloor) &&
                        (bus_if.destination != 5'd0) && (bus_if.destination <= TopFloor);
        w_target      = (r_state == StGoPick) ? r_pick : r_dest;
        w_step_floor  = r_dir_up ? (r_car_floor + 5'd1) : (r_car_floor - 5'd1);
        w_step_onehot = r_dir_up ? (r_car_onehot << 1) : (r_car_onehot >> 1);
        w_tmr_done    = (r_tmr == '0);
        w_to_idle     = w_tmr_done &&
                        (((r_state == StDoorPick) && (r_dest == r_car_floor)) ||
                         (r_state == StDoorDest));
`ifdef ELEVATOR_REQ_QUEUE_EN
        // A parked pending request owns the launch slot; edges in that cycle count as busy.
        w_busy_edge   = w_edge && ((r_state != StIdle) || r_pend_v);
        w_l_pick      = r_pend_v ? r_pend_pick : bus_if.current;
        w_l_dest      = r_pend_v ? r_pend_dest : bus_if.destination;
        w_do_launch   = ((r_state == StIdle) && (r_pend_v || (w_edge && w_in_valid))) ||
                        (w_to_idle && r_pend_v);
        w_req_reject  = ((r_state == StIdle) && !r_pend_v && w_edge && !w_in_valid) ||
                        (w_busy_edge && (!w_in_valid || r_pend_v));
`else
        w_l_pick      = bus_if.current;
        w_l_dest      = bus_if.destination;
        w_do_launch   = (r_state == StIdle) && w_edge && w_in_valid;
        w_req_reject  = (r_state == StIdle) && w_edge && !w_in_valid;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_tmr        <= '0;
            r_car_floor  <= 5'd1;
            r_car_onehot <= NUM_FLOORS'(1);
            r_dir_up     <= 1'b1;
            r_moving     <= 1'b0;
            r_door_open  <= 1'b0;
            r_busy       <= 1'b0;
            r_req_err    <= 1'b0;
            r_confirm_d  <= 1'b0;
            r_pick       <= 5'd1;
            r_dest       <= 5'd1;
        end else begin
            r_confirm_d <= bus_if.input_confirm;
            r_req_err   <= w_req_reject;
            if (w_do_launch) begin
                r_pick <= w_l_pick;
                r_dest <= w_l_dest;
                r_busy <= 1'b1;
                if (w_l_pick != r_car_floor) begin
                    r_state     <= StGoPick;
                    r_tmr       <= FloorReload;
                    r_dir_up    <= (w_l_pick > r_car_floor);
                    r_moving    <= 1'b1;
                    r_door_open <= 1'b0;
                end else begin
                    r_state     <= StDoorPick;
                    r_tmr       <= DoorReload;
                    r_moving    <= 1'b0;
                    r_door_open <= 1'b1;
                end
            end else begin
                unique case (r_state)
                    StIdle: begin
                    end
                    StGoPick, StGoDest: begin
                        if (w_tmr_done) begin
                            r_car_floor  <= w_step_floor;
                            r_car_onehot <= w_step_onehot;
                            if (w_step_floor == w_target) begin
                                r_state     <= (r_state == StGoPick) ? StDoorPick : StDoorDest;
                                r_tmr       <= DoorReload;
                                r_moving    <= 1'b0;
                                r_door_open <= 1'b1;
                            end else begin
                                r_tmr <= FloorReload;
                            end
                        end else begin
                            r_tmr <= r_tmr - TmrOne;
                        end
                    end
                    StDoorPick, StDoorDest: begin
                        if (!w_tmr_done) begin
                            r_tmr <= r_tmr - TmrOne;
                        end else if (w_to_idle) begin
                            r_state     <= StIdle;
                            r_door_open <= 1'b0;
                            r_busy      <= 1'b0;
                        end else begin
                            r_state     <= StGoDest;
                            r_tmr       <= FloorReload;
                            r_dir_up    <= (r_dest > r_car_floor);
                            r_moving    <= 1'b1;
                            r_door_open <= 1'b0;
                        end
                    end
                    default: r_state <= StIdle;
                endcase
            end
        end
    end

`ifdef ELEVATOR_REQ_QUEUE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_v    <= 1'b0;
            r_pend_pick <= 5'd1;
            r_pend_dest <= 5'd1;
        end else if (w_do_launch && r_pend_v) begin
            r_pend_v <= 1'b0;
        end else if (w_busy_edge && w_in_valid && !r_pend_v) begin
            r_pend_v    <= 1'b1;
            r_pend_pick <= bus_if.current;
            r_pend_dest <= bus_if.destination;
        end
    end
`endif

    assign bus_if.car_floor  = r_car_floor;
    assign bus_if.car_onehot = r_car_onehot;
    assign bus_if.moving     = r_moving;
    assign bus_if.dir_up     = r_dir_up;
    assign bus_if.door_open  = r_door_open;
    assign bus_if.busy       = r_busy;
    assign bus_if.req_err    = r_req_err;

endmodule

// File: tb/tb_elevator_move_ctrl.sv
// Bench for elevator_move_ctrl: request table, directed corner sequences, and random requests
// checked every cycle against a timeline model built from floor distances and tick counts.
module tb_elevator_move_ctrl;
    localparam int NF = 9;
    localparam int FT = 4;
    localparam int DT = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    elevator_move_ctrl_if #(.NUM_FLOORS(NF)) bus ();

    elevator_move_ctrl #(
        .NUM_FLOORS (NF),
        .FLOOR_TICKS(FT),
        .DOOR_TICKS (DT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus_if(bus)
    );

    typedef struct packed {
        logic [4:0] floor;
        logic       moving;
        logic       dir;
        logic       door;
        logic       busy;
        logic       err;
    } obs_t;

    typedef struct {
        int cur;
        int dst;
        bit err;
        int busy_cycles;
        int floor;
    } vec_t;

    int   n_checks = 0;
    int   n_err    = 0;
    bit   mon_en   = 1'b0;
    obs_t sched[$];
    obs_t m_cur;
    logic m_conf_d;
    bit   m_pend;
    int   m_pp, m_pq;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic obs_t mk(input logic [4:0] f, input logic mv, input logic d,
                                input logic dr, input logic b, input logic e);
        obs_t o;
        o.floor = f; o.moving = mv; o.dir = d; o.door = dr; o.busy = b; o.err = e;
        return o;
    endfunction

    function automatic bit valid_floor(input int v);
        return (v >= 1) && (v <= NF);
    endfunction

    // One leg: FT cycles shown at each floor passed, then DT door cycles at the target.
    task automatic push_leg(inout int pos, inout logic d, input int tgt);
        if (tgt != pos) begin
            d = (tgt > pos);
            while (pos != tgt) begin
                repeat (FT) sched.push_back(mk(5'(pos), 1'b1, d, 1'b0, 1'b1, 1'b0));
                pos = d ? pos + 1 : pos - 1;
            end
        end
        repeat (DT) sched.push_back(mk(5'(pos), 1'b0, d, 1'b1, 1'b1, 1'b0));
    endtask

    task automatic plan(input int p, input int q);
        int   pos = int'(m_cur.floor);
        logic d   = m_cur.dir;
        push_leg(pos, d, p);
        if (q != p) push_leg(pos, d, q);
    endtask

    task automatic model_reset();
        sched.delete();
        m_cur    = mk(5'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        m_conf_d = 1'b0;
        m_pend   = 1'b0;
    endtask

    task automatic model_step();
        bit   edge_s = bus.input_confirm && !m_conf_d;
        bit   ok     = valid_floor(int'(bus.current)) && valid_floor(int'(bus.destination));
        bit   err    = 1'b0;
        bit   store  = 1'b0;
        bit   pend_pre;
        m_conf_d = bus.input_confirm;
        if (!m_cur.busy && !m_pend) begin
            if (edge_s) begin
                if (ok) plan(int'(bus.current), int'(bus.destination));
                else    err = 1'b1;
            end
        end else begin
            pend_pre = m_pend;
`ifdef ELEVATOR_REQ_QUEUE_EN
            if (edge_s) begin
                if (!ok || m_pend) err = 1'b1;
                else               store = 1'b1;
            end
`endif
            if (sched.size() == 0 && pend_pre) begin
                plan(m_pp, m_pq);
                m_pend = 1'b0;
            end
            if (store) begin
                m_pend = 1'b1;
                m_pp   = int'(bus.current);
                m_pq   = int'(bus.destination);
            end
        end
        if (sched.size() > 0) m_cur = sched.pop_front();
        else m_cur = mk(m_cur.floor, 1'b0, m_cur.dir, 1'b0, 1'b0, 1'b0);
        m_cur.err = err;
    endtask

    always @(posedge clk) begin
        if (mon_en) begin
            obs_t            act;
            logic [NF-1:0]   exp_oh;
            model_step();
            #1;
            act    = mk(bus.car_floor, bus.moving, bus.dir_up, bus.door_open, bus.busy,
                        bus.req_err);
            exp_oh = NF'(1) << (m_cur.floor - 5'd1);
            n_checks++;
            if (act != m_cur || bus.car_onehot != exp_oh) begin
                n_err++;
                $display("FAIL cycle_model: got floor=%0d oh=%h mv=%b dir=%b door=%b busy=%b err=%b, expected floor=%0d oh=%h mv=%b dir=%b door=%b busy=%b err=%b (t=%0t)",
                         act.floor, bus.car_onehot, act.moving, act.dir, act.door, act.busy,
                         act.err, m_cur.floor, exp_oh, m_cur.moving, m_cur.dir, m_cur.door,
                         m_cur.busy, m_cur.err, $time);
            end
        end
    end

    task automatic run_req(input int c, input int d, output bit err_seen, output int cnt,
                           output int fl, output int oh);
        @(negedge clk);
        bus.current       = 5'(c);
        bus.destination   = 5'(d);
        bus.input_confirm = 1'b1;
        @(posedge clk); #1;
        err_seen          = bus.req_err;
        bus.input_confirm = 1'b0;
        cnt = 0;
        while (bus.busy && cnt < 300) begin
            cnt++;
            @(posedge clk); #1;
        end
        fl = int'(bus.car_floor);
        oh = int'(bus.car_onehot);
        @(posedge clk); #1;
        check("req_err_one_shot", int'(bus.req_err), 0);
    endtask

    task automatic wait_idle(input string name, input int limit);
        int n = 0;
        while (bus.busy && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy) check({name, "_timeout"}, 1, 0);
    endtask

    vec_t vecs[11];

    initial begin
        bit err_seen;
        int cnt, fl, oh;
        int n;

        vecs[0]  = '{3, 5, 1'b0, 22, 5};
        vecs[1]  = '{2, 2, 1'b0, 15, 2};
        vecs[2]  = '{0, 4, 1'b1, 0, 2};
        vecs[3]  = '{10, 1, 1'b1, 0, 2};
        vecs[4]  = '{9, 1, 1'b0, 66, 1};
        vecs[5]  = '{1, 1, 1'b0, 3, 1};
        vecs[6]  = '{1, 9, 1'b0, 38, 9};
        vecs[7]  = '{9, 0, 1'b1, 0, 9};
        vecs[8]  = '{31, 31, 1'b1, 0, 9};
        vecs[9]  = '{9, 8, 1'b0, 10, 8};
        vecs[10] = '{4, 4, 1'b0, 19, 4};

        bus.current       = 5'd1;
        bus.destination   = 5'd1;
        bus.input_confirm = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_car_floor", int'(bus.car_floor), 1);
        check("rst_car_onehot", int'(bus.car_onehot), 1);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_door_open", int'(bus.door_open), 0);
        check("rst_req_err", int'(bus.req_err), 0);
        check("rst_dir_up", int'(bus.dir_up), 1);
        rst_n = 1'b1;
        model_reset();
        mon_en = 1'b1;

        for (int i = 0; i < 11; i++) begin
            run_req(vecs[i].cur, vecs[i].dst, err_seen, cnt, fl, oh);
            check($sformatf("vec%0d_req_err", i), int'(err_seen), int'(vecs[i].err));
            check($sformatf("vec%0d_busy_cycles", i), cnt, vecs[i].busy_cycles);
            check($sformatf("vec%0d_final_floor", i), fl, vecs[i].floor);
            check($sformatf("vec%0d_final_onehot", i), oh, 1 << (vecs[i].floor - 1));
        end

        // Request 7->1 arrives while the car is moving on 3->5.
        @(negedge clk);
        bus.current = 5'd3; bus.destination = 5'd5; bus.input_confirm = 1'b1;
        @(negedge clk);
        bus.input_confirm = 1'b0;
        @(negedge clk);
        check("busy_edge_moving", int'(bus.moving), 1);
        bus.current = 5'd7; bus.destination = 5'd1; bus.input_confirm = 1'b1;
        @(negedge clk);
        bus.input_confirm = 1'b0;
        wait_idle("busy_edge", 400);
`ifdef ELEVATOR_REQ_QUEUE_EN
        check("busy_edge_first_idle_floor", int'(bus.car_floor), 1);
`else
        check("busy_edge_first_idle_floor", int'(bus.car_floor), 5);
`endif
        check("busy_edge_no_err", int'(bus.req_err), 0);

        // Reset pulled during the destination leg at floor 4.
        @(negedge clk);
        bus.current = 5'd3; bus.destination = 5'd5; bus.input_confirm = 1'b1;
        @(negedge clk);
        bus.input_confirm = 1'b0;
        n = 0;
        while (!bus.door_open && n < 200) begin @(negedge clk); n++; end
        check("midrst_reach_pick_door", int'(bus.door_open), 1);
        n = 0;
        while (!(bus.car_floor == 5'd4 && bus.moving) && n < 200) begin @(negedge clk); n++; end
        check("midrst_reach_floor4", int'(bus.car_floor), 4);
        @(posedge clk); #3;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("midrst_car_floor", int'(bus.car_floor), 1);
        check("midrst_car_onehot", int'(bus.car_onehot), 1);
        check("midrst_moving", int'(bus.moving), 0);
        check("midrst_busy", int'(bus.busy), 0);
        check("midrst_door_open", int'(bus.door_open), 0);
        check("midrst_dir_up", int'(bus.dir_up), 1);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        mon_en = 1'b1;

        // Random requests, including invalid floors and edges while busy.
        for (int i = 0; i < 150; i++) begin
            repeat ($urandom_range(0, 40)) @(negedge clk);
            bus.current     = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31))
                                                          : 5'($urandom_range(1, NF));
            bus.destination = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31))
                                                          : 5'($urandom_range(1, NF));
            bus.input_confirm = 1'b1;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            bus.input_confirm = 1'b0;
        end
        @(negedge clk);
        wait_idle("final_drain", 400);
        repeat (3) @(negedge clk);
        mon_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
